// File: rtl/mem_sram_ctrl_if.sv
// Split-handshake SRAM bus (req/addr_ok/data_ok) between the MEM-stage controller and memory.
interface mem_sram_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req;
  logic              wr;
  logic [3:0]        wstrb;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [31:0]       rdata;

  modport master (
    output req, wr, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/mem_sram_ctrl.sv
// MEM-stage data-memory sequencer: one outstanding access over a split-handshake SRAM bus,
// load extension, pipeline stall request, timeout and flush draining.
module mem_sram_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_mem_req,
  input  logic [3:0]        i_mem_wen,
  input  logic [2:0]        i_mem_ld_op,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [31:0]       i_mem_wdata,
  input  logic              i_flush,
  input  logic              i_adv,
  mem_sram_ctrl_if.master   sram,
  output logic              o_stallreq,
  output logic [31:0]       o_ld_data,
  output logic              o_ld_valid,
  output logic              o_bus_err
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StReq   = 3'd1;
  localparam logic [2:0] StWait  = 3'd2;
  localparam logic [2:0] StDrain = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  localparam int unsigned   CntW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT - 1);
  localparam bit            TimeoutEn = (TIMEOUT != 0);

  logic [2:0]        r_state, w_state;
  logic              r_req, w_req;
  logic              r_wr, w_wr;
  logic [3:0]        r_wstrb, w_wstrb;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [31:0]       r_wdata, w_wdata;
  logic [2:0]        r_ld_op, w_ld_op;
  logic [31:0]       r_ld_data, w_ld_data;
  logic              r_ld_valid, w_ld_valid;
  logic              r_bus_err, w_bus_err;
  logic [CntW-1:0]   r_cnt, w_cnt;
  logic              w_timeout;
  logic [31:0]       w_rd_result;

  function automatic logic [31:0] f_extend(input logic [2:0] op, input logic [1:0] lane,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = lane[1] ? d[31:16] : d[15:0];
    case (op)
      3'b001:  f_extend = {{24{b[7]}}, b};
      3'b010:  f_extend = {24'b0, b};
      3'b011:  f_extend = {{16{h[15]}}, h};
      3'b100:  f_extend = {16'b0, h};
      default: f_extend = d;
    endcase
  endfunction

  assign w_timeout   = TimeoutEn && (r_cnt == CntMax);
  // Stores report zero so consumers never see stale load data.
  assign w_rd_result = r_wr ? 32'b0 : f_extend(r_ld_op, r_addr[1:0], sram.rdata);

  always_comb begin
    w_state    = r_state;
    w_req      = r_req;
    w_wr       = r_wr;
    w_wstrb    = r_wstrb;
    w_addr     = r_addr;
    w_wdata    = r_wdata;
    w_ld_op    = r_ld_op;
    w_ld_data  = r_ld_data;
    w_ld_valid = r_ld_valid;
    w_bus_err  = r_bus_err;
    w_cnt      = r_cnt;
    case (r_state)
      StIdle: begin
        if (i_mem_req && !i_flush) begin
          w_addr  = i_mem_addr;
          w_wdata = i_mem_wdata;
          w_wstrb = i_mem_wen;
          w_wr    = |i_mem_wen;
          w_ld_op = i_mem_ld_op;
          w_req   = 1'b1;
          w_cnt   = '0;
          w_state = StReq;
        end
      end
      StReq: begin
        w_cnt = r_cnt + CntW'(1);
        if (sram.addr_ok) begin
          w_req = 1'b0;
          if (i_flush) begin
            w_state = sram.data_ok ? StIdle : StDrain;
          end else if (sram.data_ok) begin
            w_ld_data  = w_rd_result;
            w_ld_valid = 1'b1;
            w_state    = StDone;
          end else begin
            w_state = StWait;
          end
        end else if (i_flush) begin
          w_req   = 1'b0;
          w_state = StIdle;
        end else if (w_timeout) begin
          w_req      = 1'b0;
          w_bus_err  = 1'b1;
          w_ld_data  = 32'b0;
          w_ld_valid = 1'b1;
          w_state    = StDone;
        end
      end
      StWait: begin
        w_cnt = r_cnt + CntW'(1);
        if (sram.data_ok) begin
          if (i_flush) begin
            w_state = StIdle;
          end else begin
            w_ld_data  = w_rd_result;
            w_ld_valid = 1'b1;
            w_state    = StDone;
          end
        end else if (i_flush) begin
          w_state = StDrain;
        end else if (w_timeout) begin
          w_bus_err  = 1'b1;
          w_ld_data  = 32'b0;
          w_ld_valid = 1'b1;
          w_state    = StDone;
        end
      end
      StDrain: begin
        if (sram.data_ok) w_state = StIdle;
      end
      StDone: begin
        // The same instruction still holds mem_req here; only adv/flush release it.
        if (i_adv || i_flush) begin
          w_ld_valid = 1'b0;
          w_bus_err  = 1'b0;
          w_state    = StIdle;
        end
      end
      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_req      <= 1'b0;
      r_wr       <= 1'b0;
      r_wstrb    <= 4'b0;
      r_addr     <= '0;
      r_wdata    <= 32'b0;
      r_ld_op    <= 3'b0;
      r_ld_data  <= 32'b0;
      r_ld_valid <= 1'b0;
      r_bus_err  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state;
      r_req      <= w_req;
      r_wr       <= w_wr;
      r_wstrb    <= w_wstrb;
      r_addr     <= w_addr;
      r_wdata    <= w_wdata;
      r_ld_op    <= w_ld_op;
      r_ld_data  <= w_ld_data;
      r_ld_valid <= w_ld_valid;
      r_bus_err  <= w_bus_err;
      r_cnt      <= w_cnt;
    end
  end

  assign sram.req   = r_req;
  assign sram.wr    = r_wr;
  assign sram.wstrb = r_wstrb;
  assign sram.addr  = r_addr;
  assign sram.wdata = r_wdata;

  assign o_stallreq = ((r_state == StIdle) && i_mem_req && !i_flush) || (r_state == StReq) ||
                      (r_state == StWait) || (r_state == StDrain);
  assign o_ld_data  = r_ld_data;
  assign o_ld_valid = r_ld_valid;
  assign o_bus_err  = r_bus_err;

endmodule
